// File: rtl/pulse_train_generator_pkg.sv
// Shared definitions for the pulse train generator: FSM state encoding and
// the minimum effective period rule (one tick high plus at least one tick low).
package pulse_train_generator_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int DEFAULT_PULSE_WIDTH = 1;
  localparam int DEFAULT_MIN_PERIOD  = DEFAULT_PULSE_WIDTH + 1;

  function automatic int min_eff_period(input int pulse_width);
    return pulse_width + 1;
  endfunction

endpackage

// File: rtl/pulse_train_generator_tick_prescaler.sv
// Reloadable down-counter producing a one-clock tick every PRESCALER clocks.
// While hold is high the counter sits at PRESCALER-1 and no tick is produced.
module pulse_train_generator_tick_prescaler #(
  parameter int PRESCALER = 30
) (
  input  logic clk,
  input  logic reset,
  input  logic hold,
  output logic tick
);

  localparam int CNT_W = (PRESCALER > 1) ? $clog2(PRESCALER) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(PRESCALER - 1);

  logic [CNT_W-1:0] count;

  assign tick = !hold && (count == '0);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of always_ff ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= RELOAD;
    end else if (hold || tick) begin
      count <= RELOAD;
    end else begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/pulse_train_generator.sv
// Periodic pulse train: period in prescaled ticks, glitch-free period updates at
// period boundaries. Optional pulse counter output when PULSE_TRAIN_COUNT_EN is defined.
module pulse_train_generator
  import pulse_train_generator_pkg::*;
#(
  parameter int PERIOD_NOB  = 11,
  parameter int PRESCALER   = 30,
  parameter int PULSE_WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  load,
  input  logic [PERIOD_NOB-1:0] period,
  output logic                  out,
  output logic                  running
`ifdef PULSE_TRAIN_COUNT_EN
  ,
  output logic [15:0]           pulse_count
`endif
);

  localparam logic [PERIOD_NOB-1:0] MIN_PERIOD = PERIOD_NOB'(min_eff_period(PULSE_WIDTH));
  localparam logic [PERIOD_NOB-1:0] PW         = PERIOD_NOB'(PULSE_WIDTH);

  state_e                state;
  logic [PERIOD_NOB-1:0] shadow;
  logic [PERIOD_NOB-1:0] active;
  logic [PERIOD_NOB-1:0] phase;
  logic [PERIOD_NOB-1:0] phase_inc;
  logic [PERIOD_NOB-1:0] eff_period;
  logic [PERIOD_NOB-1:0] next_active;
  logic                  tick;
  logic                  hold;
  logic                  boundary;

  // Clamp only on compare; the stored period stays as programmed.
  assign eff_period  = (active < MIN_PERIOD) ? MIN_PERIOD : active;
  assign phase_inc   = phase + 1'b1;
  assign boundary    = tick && (phase == eff_period - 1'b1);
  assign next_active = load ? period : shadow;
  assign hold        = (state == ST_IDLE) || !en;

  pulse_train_generator_tick_prescaler #(
    .PRESCALER(PRESCALER)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .hold (hold),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      shadow  <= '0;
      active  <= '0;
      phase   <= '0;
      out     <= 1'b0;
      running <= 1'b0;
`ifdef PULSE_TRAIN_COUNT_EN
      pulse_count <= '0;
`endif
    end else begin
      if (load) shadow <= period;
      case (state)
        ST_IDLE: begin
          phase   <= '0;
          out     <= 1'b0;
          running <= 1'b0;
          if (load) active <= period;
          if (en && (active != '0)) begin
            state   <= ST_RUN;
            out     <= 1'b1;
            running <= 1'b1;
`ifdef PULSE_TRAIN_COUNT_EN
            pulse_count <= pulse_count + 1'b1;
`endif
          end
        end
        ST_RUN: begin
          if (!en) begin
            state   <= ST_IDLE;
            phase   <= '0;
            out     <= 1'b0;
            running <= 1'b0;
          end else if (boundary) begin
            // A load landing on the boundary bypasses the shadow register.
            active <= next_active;
            phase  <= '0;
            if (next_active == '0) begin
              state   <= ST_IDLE;
              out     <= 1'b0;
              running <= 1'b0;
            end else begin
              out <= 1'b1;
`ifdef PULSE_TRAIN_COUNT_EN
              pulse_count <= pulse_count + 1'b1;
`endif
            end
          end else if (tick) begin
            phase <= phase_inc;
            out   <= (phase_inc < PW);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_train_generator.sv
// Directed bench for pulse_train_generator with PRESCALER=4, PULSE_WIDTH=1.
// Outputs are sampled on the falling clock edge; inputs change right after sampling.
module tb_pulse_train_generator;

  localparam int PERIOD_NOB  = 11;
  localparam int PRESCALER   = 4;
  localparam int PULSE_WIDTH = 1;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  en;
  logic                  load;
  logic [PERIOD_NOB-1:0] period;
  logic                  out;
  logic                  running;
`ifdef PULSE_TRAIN_COUNT_EN
  logic [15:0]           pulse_count;
`endif

  int tests  = 0;
  int failed = 0;
  int n;

  always #5 clk = ~clk;

  pulse_train_generator #(
    .PERIOD_NOB (PERIOD_NOB),
    .PRESCALER  (PRESCALER),
    .PULSE_WIDTH(PULSE_WIDTH)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .load   (load),
    .period (period),
    .out    (out),
    .running(running)
`ifdef PULSE_TRAIN_COUNT_EN
    ,
    .pulse_count(pulse_count)
`endif
  );

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Steps falling edges until out equals lvl; n is the step count, -1 on timeout.
  task automatic wait_level(input logic lvl, input int budget, output int cnt);
    cnt = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (out === lvl) begin
        cnt = i;
        break;
      end
    end
  endtask

  task automatic pulse_load(input logic [PERIOD_NOB-1:0] p);
    period = p;
    load   = 1'b1;
    @(negedge clk);
    load   = 1'b0;
  endtask

  initial begin
    reset  = 1'b1;
    en     = 1'b0;
    load   = 1'b0;
    period = '0;
    repeat (2) @(negedge clk);
    check("reset out", int'(out), 0);
    check("reset running", int'(running), 0);
    reset = 1'b0;
    @(negedge clk);

    // Test 1: period 3 -> 4 high / 8 low, period input change without load ignored
    pulse_load(11'd3);
    check("idle after load out", int'(out), 0);
    check("idle after load running", int'(running), 0);
    period = 11'd7;
    en = 1'b1;
    wait_level(1'b1, 20, n);
    check("t1 rise latency", n, 1);
    check("t1 running", int'(running), 1);
    for (int p = 0; p < 5; p++) begin
      wait_level(1'b0, 40, n);
      check("t1 high clocks", n, 4);
      wait_level(1'b1, 40, n);
      check("t1 low clocks", n, 8);
    end

    // Test 2: mid-period load takes effect at the next boundary
    wait_level(1'b0, 40, n);
    check("t2 high before load", n, 4);
    pulse_load(11'd5);
    wait_level(1'b1, 40, n);
    check("t2 old period low rest", n, 7);
    wait_level(1'b0, 40, n);
    check("t2 new period high", n, 4);
    wait_level(1'b1, 40, n);
    check("t2 new period low", n, 16);

    // Test 2b: load on the boundary cycle applies immediately
    wait_level(1'b0, 40, n);
    check("t2b high", n, 4);
    repeat (15) @(negedge clk);
    check("t2b out before boundary", int'(out), 0);
    pulse_load(11'd3);
    check("t2b rise at boundary", int'(out), 1);
    wait_level(1'b0, 40, n);
    check("t2b bypass high", n, 4);
    wait_level(1'b1, 40, n);
    check("t2b bypass low", n, 8);

    // Test 3: period 1 clamps to 2 ticks, then period 0 stops at the boundary
    wait_level(1'b0, 40, n);
    check("t3 high", n, 4);
    pulse_load(11'd1);
    wait_level(1'b1, 40, n);
    check("t3 old period low rest", n, 7);
    wait_level(1'b0, 40, n);
    check("t3 clamped high", n, 4);
    wait_level(1'b1, 40, n);
    check("t3 clamped low", n, 4);
    wait_level(1'b0, 40, n);
    check("t3 clamped high 2", n, 4);
    pulse_load(11'd0);
    repeat (2) @(negedge clk);
    check("t3 running before boundary", int'(running), 1);
    @(negedge clk);
    check("t3 running after stop", int'(running), 0);
    check("t3 out after stop", int'(out), 0);
    wait_level(1'b1, 40, n);
    check("t3 no edges after stop", n, -1);

    // Test 4: en drop mid-high, then restart with a full high time
    pulse_load(11'd3);
    check("t4 out at load", int'(out), 0);
    wait_level(1'b1, 20, n);
    check("t4 rise latency", n, 1);
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    check("t4 out after en drop", int'(out), 0);
    check("t4 running after en drop", int'(running), 0);
    en = 1'b1;
    wait_level(1'b1, 20, n);
    check("t4 restart latency", n, 1);
    wait_level(1'b0, 40, n);
    check("t4 restart high", n, 4);
    wait_level(1'b1, 40, n);
    check("t4 restart low", n, 8);

    // Test 5: asynchronous reset mid-high clears outputs without a clock edge
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("t5 async reset out", int'(out), 0);
    check("t5 async reset running", int'(running), 0);
    @(negedge clk);
    reset = 1'b0;
    wait_level(1'b1, 40, n);
    check("t5 no pulses with active 0", n, -1);
    pulse_load(11'd3);
    wait_level(1'b1, 20, n);
    check("t5 rise after load", n, 1);

`ifdef PULSE_TRAIN_COUNT_EN
    check("t6 count first pulse", int'(pulse_count), 1);
    for (int p = 0; p < 9; p++) begin
      wait_level(1'b0, 40, n);
      wait_level(1'b1, 40, n);
    end
    check("t6 count ten pulses", int'(pulse_count), 10);
    @(negedge clk);
    force dut.pulse_count = 16'hFFFF;
    @(negedge clk);
    release dut.pulse_count;
    wait_level(1'b0, 40, n);
    wait_level(1'b1, 40, n);
    check("t6 count wrap", int'(pulse_count), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
